// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, idle-high line.
// Deserialises each frame and presents the byte with a one-cycle valid strobe.
// Frames whose stop bit samples low raise a one-cycle framing-error strobe.
//
// Optional build macro UART_RX_MAJORITY_EN: every sample (start, data, stop)
// takes the 2-of-3 majority of the last three synchronised line values,
// rejecting a single-cycle glitch at a sample instant. Ports and timing are
// identical with and without the macro.
//
// Parameters:
//   clks_per_bit   clock cycles per serial bit (>= 8)
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   Rx_Serial      asynchronous serial input, idle high
//   Rx_Parallel    last correctly framed byte, held until the next good frame
//   Rx_Valid       one-cycle pulse, Rx_Parallel updated this cycle
//   Framing_Error  one-cycle pulse, stop bit sampled low
//   Busy           high whenever the receiver is not idle
module uart_rx #(
   parameter int unsigned clks_per_bit = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Rx_Serial,
   output logic [7:0] Rx_Parallel,
   output logic       Rx_Valid,
   output logic       Framing_Error,
   output logic       Busy
);

   localparam int unsigned HALF_BIT = (clks_per_bit - 1) / 2;
   localparam int unsigned CNT_W    = $clog2(clks_per_bit);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(clks_per_bit - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK_WAIT
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] clk_count_q;
   logic [2:0]       bit_index_q;
   logic [7:0]       shift_q;
   logic [7:0]       rx_parallel_q;
   logic             rx_valid_q;
   logic             framing_error_q;
   logic             busy_q;
   logic             rx_meta_q;
   logic             rx_s_q;
   logic             sample_c;

   // Two-flop synchroniser; resets to the idle line level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= Rx_Serial;
         rx_s_q    <= rx_meta_q;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   // Two previous rx_s values; together with rx_s they form the 3-deep history.
   logic [1:0] hist_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= {hist_q[0], rx_s_q};
      end
   end

   assign sample_c = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
   assign sample_c = rx_s_q;
`endif

   // Receive FSM: counters, shift register and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         clk_count_q     <= '0;
         bit_index_q     <= 3'd0;
         shift_q         <= 8'h00;
         rx_parallel_q   <= 8'h00;
         rx_valid_q      <= 1'b0;
         framing_error_q <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         rx_valid_q      <= 1'b0;
         framing_error_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               clk_count_q <= '0;
               bit_index_q <= 3'd0;
               if (!rx_s_q) begin
                  state_q <= ST_START;
                  busy_q  <= 1'b1;
               end
            end

            // Re-check the start bit at mid-bit; a high sample is a false start.
            ST_START: begin
               if (clk_count_q == HALF_CNT) begin
                  clk_count_q <= '0;
                  if (!sample_c) begin
                     state_q <= ST_DATA;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  clk_count_q <= clk_count_q + CNT_W'(1);
               end
            end

            ST_DATA: begin
               if (clk_count_q == LAST_CNT) begin
                  clk_count_q          <= '0;
                  shift_q[bit_index_q] <= sample_c;
                  if (bit_index_q == 3'd7) begin
                     bit_index_q <= 3'd0;
                     state_q     <= ST_STOP;
                  end else begin
                     bit_index_q <= bit_index_q + 3'd1;
                  end
               end else begin
                  clk_count_q <= clk_count_q + CNT_W'(1);
               end
            end

            // Leave at mid-stop-bit so a back-to-back start edge is not missed.
            ST_STOP: begin
               if (clk_count_q == LAST_CNT) begin
                  clk_count_q <= '0;
                  if (sample_c) begin
                     rx_parallel_q <= shift_q;
                     rx_valid_q    <= 1'b1;
                     state_q       <= ST_IDLE;
                     busy_q        <= 1'b0;
                  end else begin
                     framing_error_q <= 1'b1;
                     state_q         <= ST_BREAK_WAIT;
                  end
               end else begin
                  clk_count_q <= clk_count_q + CNT_W'(1);
               end
            end

            // Hold off until the line returns high so a break yields one error only.
            ST_BREAK_WAIT: begin
               clk_count_q <= '0;
               if (rx_s_q) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Rx_Parallel   = rx_parallel_q;
   assign Rx_Valid      = rx_valid_q;
   assign Framing_Error = framing_error_q;
   assign Busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at clks_per_bit=16.
// Frames are serialised cycle by cycle on the falling clock edge; a monitor
// records every Rx_Valid / Framing_Error pulse for later checks.
module tb_uart_rx;

   localparam int unsigned CPB   = 16;
   localparam int          FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] Rx_Parallel;
   logic       Rx_Valid;
   logic       Framing_Error;
   logic       Busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;

   int         valid_cnt = 0;
   int         fe_cnt    = 0;
   int         both_cnt  = 0;
   int         t_valid   = 0;
   logic [7:0] par_at_fe = 8'h00;
   logic [7:0] got_q[$];

   int v0;
   int f0;
   int n0;
   int exp_glitch;

   uart_rx #(.clks_per_bit(CPB)) dut (
      .clk           (clk),
      .reset         (reset),
      .Rx_Serial     (rx),
      .Rx_Parallel   (Rx_Parallel),
      .Rx_Valid      (Rx_Valid),
      .Framing_Error (Framing_Error),
      .Busy          (Busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (Rx_Valid) begin
            valid_cnt = valid_cnt + 1;
            got_q.push_back(Rx_Parallel);
            t_valid = cyc;
         end
         if (Framing_Error) begin
            fe_cnt    = fe_cnt + 1;
            par_at_fe = Rx_Parallel;
         end
         if (Rx_Valid && Framing_Error) both_cnt = both_cnt + 1;
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive ncyc cycles of a frame {stop, data, start}; cycle 'glitch' is forced high.
   task automatic drive_frame(input logic [7:0] d, input logic stop, input int glitch,
                              input int ncyc);
      logic [9:0] fr;
      fr = {stop, d, 1'b0};
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (c == 0) t0 = cyc;
         rx = (c == glitch) ? 1'b1 : fr[c / CPB];
      end
   endtask

   task automatic line(input logic lvl, input int n);
      repeat (n) begin
         @(negedge clk);
         rx = lvl;
      end
   endtask

   function automatic int last_byte();
      if (got_q.size() == 0) return -1;
      return int'(got_q[got_q.size() - 1]);
   endfunction

   initial begin
      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_parallel", int'(Rx_Parallel), 8'h00);
      check("rst_valid", int'(Rx_Valid), 0);
      check("rst_ferr", int'(Framing_Error), 0);
      check("rst_busy", int'(Busy), 0);
      reset = 1'b0;
      line(1'b1, 5);

      // Single frame 0xA5 with latency check.
      v0 = valid_cnt;
      f0 = fe_cnt;
      drive_frame(8'hA5, 1'b1, -1, FRAME);
      line(1'b1, 4);
      check("a5_valid_cnt", valid_cnt - v0, 1);
      check("a5_byte", last_byte(), 8'hA5);
      check("a5_ferr_cnt", fe_cnt - f0, 0);
      check("a5_busy_after", int'(Busy), 0);
      check("a5_latency", t_valid - t0, 155);

      // Back-to-back frames with a single stop bit.
      v0 = valid_cnt;
      n0 = got_q.size();
      drive_frame(8'h00, 1'b1, -1, FRAME);
      drive_frame(8'hFF, 1'b1, -1, FRAME);
      drive_frame(8'h81, 1'b1, -1, FRAME);
      line(1'b1, 4);
      check("b2b_valid_cnt", valid_cnt - v0, 3);
      check("b2b_byte0", (got_q.size() > n0)     ? int'(got_q[n0])     : -1, 8'h00);
      check("b2b_byte1", (got_q.size() > n0 + 1) ? int'(got_q[n0 + 1]) : -1, 8'hFF);
      check("b2b_byte2", (got_q.size() > n0 + 2) ? int'(got_q[n0 + 2]) : -1, 8'h81);
      check("b2b_ferr_cnt", fe_cnt - f0, 0);

      // Bad stop bit, line held low for 3 bit times, then a good frame.
      v0 = valid_cnt;
      f0 = fe_cnt;
      drive_frame(8'h3C, 1'b0, -1, FRAME);
      line(1'b0, 3 * CPB);
      check("brk_ferr_cnt", fe_cnt - f0, 1);
      check("brk_par_at_ferr", int'(par_at_fe), 8'h81);
      check("brk_par_hold", int'(Rx_Parallel), 8'h81);
      check("brk_valid_cnt", valid_cnt - v0, 0);
      check("brk_busy_low_line", int'(Busy), 1);
      line(1'b1, 20);
      check("brk_busy_released", int'(Busy), 0);
      drive_frame(8'h3C, 1'b1, -1, FRAME);
      line(1'b1, 4);
      check("brk_recover_valid", valid_cnt - v0, 1);
      check("brk_recover_byte", last_byte(), 8'h3C);
      check("brk_ferr_total", fe_cnt - f0, 1);

      // 4-cycle low glitch on an idle line is a false start.
      v0 = valid_cnt;
      f0 = fe_cnt;
      line(1'b0, 4);
      line(1'b1, 2);
      check("fs_busy_in_start", int'(Busy), 1);
      line(1'b1, 7);
      check("fs_busy_cleared", int'(Busy), 0);
      line(1'b1, 10);
      check("fs_valid_cnt", valid_cnt - v0, 0);
      check("fs_ferr_cnt", fe_cnt - f0, 0);

      // Reset during data bit 4 of 0xF0, then frame 0x5A.
      v0 = valid_cnt;
      f0 = fe_cnt;
      drive_frame(8'hF0, 1'b1, -1, 88);
      @(negedge clk);
      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_parallel", int'(Rx_Parallel), 8'h00);
      check("mid_rst_busy", int'(Busy), 0);
      check("mid_rst_valid", int'(Rx_Valid), 0);
      check("mid_rst_ferr", int'(Framing_Error), 0);
      reset = 1'b0;
      line(1'b1, 3 * CPB);
      check("abort_valid_cnt", valid_cnt - v0, 0);
      check("abort_ferr_cnt", fe_cnt - f0, 0);
      drive_frame(8'h5A, 1'b1, -1, FRAME);
      line(1'b1, 4);
      check("post_rst_valid", valid_cnt - v0, 1);
      check("post_rst_byte", last_byte(), 8'h5A);

      // Frame 0x00 with a one-cycle high glitch aligned to the bit-3 sample.
`ifdef UART_RX_MAJORITY_EN
      exp_glitch = 8'h00;
`else
      exp_glitch = 8'h08;
`endif
      v0 = valid_cnt;
      drive_frame(8'h00, 1'b1, 4 * CPB + 8, FRAME);
      line(1'b1, 4);
      check("glitch_valid_cnt", valid_cnt - v0, 1);
      check("glitch_byte", last_byte(), exp_glitch);

      check("valid_ferr_overlap", both_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
